alu_issue: RTL and testbench

- Producer end of the ALU operand/opcode interface: takes one decoded-stage RV32I instruction plus its register-file read data and drives aluIn1/aluIn2/aluOp to the ALU through a registered valid/ready pipeline stage.
- Sits between the register-read stage and the execute stage.
- Performs the opcode → ALU op mapping, immediate generation, operand selection and backpressure buffering.

---
 rtl/alu_issue.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_issue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// RV32I issue stage: decodes one instruction into ALU operands/opcode and registers it toward execute.
// Latency 1 cycle (accept at edge N, visible after edge N); outputs hold while out_valid & ~out_ready.
// Backpressure: SKID_BUFFER_EN adds a skid entry with registered in_ready; otherwise in_ready = ~out_valid | out_ready.
module alu_issue #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluIn1,
  output logic [XLEN-1:0] aluIn2,
  output logic [3:0]      aluOp,
  output logic [31:0]     out_pc,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_is_branch,
  output logic            out_illegal
);

  localparam logic [3:0] ALU_ADD  = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT  = 4'b0010,
                         ALU_SLTU = 4'b0011, ALU_XOR = 4'b0100, ALU_SRL  = 4'b0101,
                         ALU_OR   = 4'b0110, ALU_AND = 4'b0111, ALU_SUB  = 4'b1000,
                         ALU_EQ   = 4'b1001, ALU_GE  = 4'b1010, ALU_GEU  = 4'b1011,
                         ALU_NEQ  = 4'b1100, ALU_SRA = 4'b1101;

  localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011,
                         OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL    = 7'b1101111, OPC_JALR  = 7'b1100111,
                         OPC_LOAD   = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [3:0]      op;
    logic [31:0]     pc;
    logic [4:0]      rd;
    logic            wen;
    logic            is_branch;
    logic            illegal;
  } issue_t;

  localparam issue_t RESET_ENTRY = '{in1: '0, in2: '0, op: ALU_ADD, pc: RESET_PC_TAG,
                                     rd: '0, wen: 1'b0, is_branch: 1'b0, illegal: 1'b0};

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic [XLEN-1:0] imm_i, imm_s, imm_u;
  issue_t          dec;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7_5 = in_instr[30];
  assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u    = {in_instr[31:12], 12'b0};

  always_comb begin
    dec           = '0;
    dec.op        = ALU_ADD;
    dec.pc        = in_pc;
    dec.rd        = in_instr[11:7];
    case (opcode)
      OPC_OP: begin
        dec.in1 = in_rs1_data;
        dec.in2 = in_rs2_data;
        dec.wen = 1'b1;
        case (funct3)
          3'b000:  dec.op = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b001:  dec.op = ALU_SLL;
          3'b010:  dec.op = ALU_SLT;
          3'b011:  dec.op = ALU_SLTU;
          3'b100:  dec.op = ALU_XOR;
          3'b101:  dec.op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.op = ALU_OR;
          default: dec.op = ALU_AND;
        endcase
      end
      OPC_OPIMM: begin
        dec.in1 = in_rs1_data;
        dec.in2 = imm_i;
        dec.wen = 1'b1;
        case (funct3)
          3'b000:  dec.op = ALU_ADD;
          3'b001:  dec.op = ALU_SLL;
          3'b010:  dec.op = ALU_SLT;
          3'b011:  dec.op = ALU_SLTU;
          3'b100:  dec.op = ALU_XOR;
          3'b101:  dec.op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec.op = ALU_OR;
          default: dec.op = ALU_AND;
        endcase
        // Shifts carry only the shamt; the funct7 bits in imm[11:5] are opcode, not operand.
        if (funct3 == 3'b001 || funct3 == 3'b101) dec.in2 = {27'b0, in_instr[24:20]};
      end
      OPC_LUI: begin
        dec.in2 = imm_u;
        dec.wen = 1'b1;
      end
      OPC_AUIPC: begin
        dec.in1 = in_pc;
        dec.in2 = imm_u;
        dec.wen = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.in1 = in_pc;
        dec.in2 = 32'd4;
        dec.wen = 1'b1;
      end
      OPC_LOAD: begin
        dec.in1 = in_rs1_data;
        dec.in2 = imm_i;
        dec.wen = 1'b1;
      end
      OPC_STORE: begin
        dec.in1 = in_rs1_data;
        dec.in2 = imm_s;
      end
      OPC_BRANCH: begin
        dec.in1       = in_rs1_data;
        dec.in2       = in_rs2_data;
        dec.is_branch = 1'b1;
        case (funct3)
          3'b000:  dec.op = ALU_EQ;
          3'b001:  dec.op = ALU_NEQ;
          3'b100:  dec.op = ALU_SLT;
          3'b101:  dec.op = ALU_GE;
          3'b110:  dec.op = ALU_SLTU;
          3'b111:  dec.op = ALU_GEU;
          default: begin
            dec.in1       = '0;
            dec.in2       = '0;
            dec.is_branch = 1'b0;
            dec.illegal   = 1'b1;
          end
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.wen = 1'b0;
  end

  issue_t main_q, main_d;
  logic   main_vld_q, main_vld_d;
  logic   accept;

  assign accept = in_valid & in_ready;

`ifdef SKID_BUFFER_EN
  issue_t skid_q, skid_d;
  logic   skid_vld_q, skid_vld_d;

  assign in_ready = ~skid_vld_q;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (!main_vld_q || out_ready) begin
      // in_ready is low whenever skid is occupied, so skid refill and accept never coincide.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q     <= RESET_ENTRY;
      skid_vld_q <= 1'b0;
    end else begin
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
`else
  assign in_ready = ~main_vld_q | out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    if (accept) begin
      main_d     = dec;
      main_vld_d = 1'b1;
    end else if (out_ready) begin
      main_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= RESET_ENTRY;
      main_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
    end
  end

  assign out_valid     = main_vld_q;
  assign aluIn1        = main_q.in1;
  assign aluIn2        = main_q.in2;
  assign aluOp         = main_q.op;
  assign out_pc        = main_q.pc;
  assign out_rd        = main_q.rd;
  assign out_wen       = main_q.wen;
  assign out_is_branch = main_q.is_branch;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, async reset, illegal encoding and backpressure ordering.
module tb_alu_issue;
  localparam logic [31:0] PC_TAG = 32'hDEAD_0000;
  localparam logic [31:0] ADDI_X1 = 32'h0000_8093; // addi x1,x1,0

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_rs1_data = '0;
  logic [31:0] in_rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] aluIn1, aluIn2, out_pc;
  logic [3:0]  aluOp;
  logic [4:0]  out_rd;
  logic        out_wen, out_is_branch, out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue #(.XLEN(32), .RESET_PC_TAG(PC_TAG)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOp(aluOp), .out_pc(out_pc), .out_rd(out_rd),
    .out_wen(out_wen), .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one instruction with out_ready high; returns #1 after the accepting edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    int waited;
    in_instr = instr; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) chk("issue_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] got_q[$];
  int          src_idx;
  logic        adv;
`ifdef SKID_BUFFER_EN
  localparam logic EXP_RDY_C1 = 1'b1;
`else
  localparam logic EXP_RDY_C1 = 1'b0;
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_op", {28'b0, aluOp}, 32'd0);
    chk("rst_pc", out_pc, PC_TAG);
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Mid-stream async reset
    issue(ADDI_X1, 32'h40, 32'd5, 32'd0);
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_in1", aluIn1, 32'd5);
    out_ready = 1'b0;
    #2; rst = 1'b1; #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_in1", aluIn1, 32'd0);
    chk("async_pc", out_pc, PC_TAG);
    chk("async_wen", {31'b0, out_wen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rdy", {31'b0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'b0, out_valid}, 32'd0);

    // sub x0,x1,x2
    issue(32'h4020_8033, 32'h10, 32'd7, 32'd3);
    chk("sub_valid", {31'b0, out_valid}, 32'd1);
    chk("sub_op", {28'b0, aluOp}, 32'h8);
    chk("sub_in1", aluIn1, 32'd7);
    chk("sub_in2", aluIn2, 32'd3);
    chk("sub_rd", {27'b0, out_rd}, 32'd0);
    chk("sub_wen", {31'b0, out_wen}, 32'd0);
    chk("sub_pc", out_pc, 32'h10);
    @(posedge clk); #1;
    chk("single_issue", {31'b0, out_valid}, 32'd0);

    // xori x1,x1,-1
    issue(32'hFFF0_C093, 32'h14, 32'h0F0F_0F0F, 32'd0);
    chk("xori_op", {28'b0, aluOp}, 32'h4);
    chk("xori_in1", aluIn1, 32'h0F0F_0F0F);
    chk("xori_in2", aluIn2, 32'hFFFF_FFFF);
    chk("xori_wen", {31'b0, out_wen}, 32'd1);
    chk("xori_rd", {27'b0, out_rd}, 32'd1);

    // bgeu / blt
    issue(32'h0020_F463, 32'h100, 32'd1, 32'd2);
    chk("bgeu_op", {28'b0, aluOp}, 32'hB);
    chk("bgeu_br", {31'b0, out_is_branch}, 32'd1);
    chk("bgeu_wen", {31'b0, out_wen}, 32'd0);
    chk("bgeu_pc", out_pc, 32'h100);
    issue(32'h0020_C463, 32'h104, 32'd1, 32'd2);
    chk("blt_op", {28'b0, aluOp}, 32'h2);

    // srai x1,x1,2 ; lui x1,0x12345 ; auipc x2,1 ; jal x1,0 ; sw x2,8(x1)
    issue(32'h4020_D093, 32'h108, 32'h8000_0000, 32'd0);
    chk("srai_op", {28'b0, aluOp}, 32'hD);
    chk("srai_in2", aluIn2, 32'd2);
    issue(32'h1234_50B7, 32'h10C, 32'd9, 32'd9);
    chk("lui_in1", aluIn1, 32'd0);
    chk("lui_in2", aluIn2, 32'h1234_5000);
    issue(32'h0000_1117, 32'h200, 32'd9, 32'd9);
    chk("auipc_in1", aluIn1, 32'h200);
    chk("auipc_in2", aluIn2, 32'h1000);
    issue(32'h0000_00EF, 32'h300, 32'd9, 32'd9);
    chk("jal_in1", aluIn1, 32'h300);
    chk("jal_in2", aluIn2, 32'd4);
    chk("jal_wen", {31'b0, out_wen}, 32'd1);
    issue(32'h0020_A423, 32'h304, 32'h1000, 32'd9);
    chk("sw_in1", aluIn1, 32'h1000);
    chk("sw_in2", aluIn2, 32'd8);
    chk("sw_wen", {31'b0, out_wen}, 32'd0);

    // Illegal encoding
    issue(32'h0000_007F, 32'h400, 32'd11, 32'd12);
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_flag", {31'b0, out_illegal}, 32'd1);
    chk("ill_op", {28'b0, aluOp}, 32'd0);
    chk("ill_in1", aluIn1, 32'd0);
    chk("ill_in2", aluIn2, 32'd0);
    chk("ill_wen", {31'b0, out_wen}, 32'd0);
    @(posedge clk); #1;
    chk("ill_drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: A..D back to back, out_ready low on cycles 1..3
    src_idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 3);
      if (src_idx < 4) begin
        in_valid    = 1'b1;
        in_instr    = ADDI_X1;
        in_pc       = 32'h500 + 32'(src_idx * 4);
        in_rs1_data = 32'hA0 + 32'(src_idx);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 1) chk("bp_rdy_c1", {31'b0, in_ready}, {31'b0, EXP_RDY_C1});
      if (cyc == 2) chk("bp_rdy_c2", {31'b0, in_ready}, 32'd0);
      if (cyc >= 1 && cyc <= 3) chk("bp_hold", aluIn1, 32'hA0);
      if (out_valid && out_ready) got_q.push_back(aluIn1);
      adv = in_valid && in_ready;
      @(posedge clk); #1;
      if (adv) src_idx++;
    end
    in_valid = 1'b0;
    chk("bp_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("bp_order%0d", i), (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, 32'hA0 + 32'(i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
